// File: rtl/debug_uart_pkg.sv
// debug_uart_pkg: UART framing constants, state encoding and byte helpers
// shared by the debug word transmitter and the command receiver.
package debug_uart_pkg;
   localparam logic UART_START_BIT = 1'b0;
   localparam logic UART_STOP_BIT = 1'b1;
   localparam int UART_DATA_BITS = 8;
   localparam int WORD_BYTES = 4;
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_e;
   // Out-of-range byte counts fall back to a full word.
   function automatic logic [2:0] clamp_nbytes(input logic [2:0] n);
      return (n == 3'd0 || n > 3'(WORD_BYTES)) ? 3'(WORD_BYTES) : n;
   endfunction
   function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] i);
      return w[8*i +: 8];
   endfunction
endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running divider that pulses tick once every BAUD_DIV
// enabled cycles; clear restarts the period from zero.
module baud_tick_gen #(
   parameter int BAUD_DIV = 868
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   always_comb begin
      tick = enable && cnt_q == LAST;
      cnt_d = (clear || tick) ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_word_tx.sv
// uart_word_tx: sends a 32-bit debug word as 1-4 back-to-back 8N1 frames,
// least significant byte first, with registered line and handshake outputs.
module uart_word_tx
   import debug_uart_pkg::*;
#(
   parameter int BAUD_DIV = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] in_data,
   input  logic [2:0]  in_nbytes,
   output logic        in_ready,
   output logic        tx,
   output logic        busy,
   output logic        done
);
   uart_state_e state_q, state_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  nbytes_q, nbytes_d, bit_q, bit_d;
   logic [1:0]  byte_q, byte_d;
   logic        tx_q, tx_d, busy_q, busy_d, rdy_q, rdy_d, done_q, done_d;
   logic        accept, tick;
   assign accept = in_valid && rdy_q;
   baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
      .clk(clk), .rst(rst), .clear(accept), .enable(busy_q), .tick(tick)
   );
   always_comb begin
      state_d = state_q;
      data_d = data_q;
      shift_d = shift_q;
      nbytes_d = nbytes_q;
      bit_d = bit_q;
      byte_d = byte_q;
      tx_d = tx_q;
      busy_d = busy_q;
      rdy_d = rdy_q;
      done_d = 1'b0;
      unique case (state_q)
         ST_IDLE: if (accept) begin
            state_d = ST_START;
            data_d = in_data;
            nbytes_d = clamp_nbytes(in_nbytes);
            shift_d = in_data[7:0];
            byte_d = '0;
            bit_d = '0;
            tx_d = UART_START_BIT;
            busy_d = 1'b1;
            rdy_d = 1'b0;
         end
         ST_START: if (tick) begin
            state_d = ST_DATA;
            bit_d = '0;
            tx_d = shift_q[0];
         end
         ST_DATA: if (tick) begin
            if (bit_q == 3'(UART_DATA_BITS - 1)) begin
               state_d = ST_STOP;
               tx_d = UART_STOP_BIT;
            end else begin
               shift_d = shift_q >> 1;
               tx_d = shift_q[1];
               bit_d = bit_q + 3'd1;
            end
         end
         ST_STOP: if (tick) begin
            // Next start bit follows the stop bit with no idle gap.
            if ({1'b0, byte_q} + 3'd1 < nbytes_q) begin
               state_d = ST_START;
               byte_d = byte_q + 2'd1;
               shift_d = word_byte(data_q, byte_q + 2'd1);
               tx_d = UART_START_BIT;
            end else begin
               state_d = ST_IDLE;
               busy_d = 1'b0;
               rdy_d = 1'b1;
               done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         data_q <= '0;
         shift_q <= '0;
         nbytes_q <= 3'(WORD_BYTES);
         bit_q <= '0;
         byte_q <= '0;
         tx_q <= 1'b1;
         busy_q <= 1'b0;
         rdy_q <= 1'b1;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q <= data_d;
         shift_q <= shift_d;
         nbytes_q <= nbytes_d;
         bit_q <= bit_d;
         byte_q <= byte_d;
         tx_q <= tx_d;
         busy_q <= busy_d;
         rdy_q <= rdy_d;
         done_q <= done_d;
      end
   end
   assign in_ready = rdy_q;
   assign tx = tx_q;
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed vector table plus hand-written corner sequences
// for the debug word transmitter at BAUD_DIV=4.
module tb_uart_word_tx;
   localparam int BD = 4;
   localparam int FRAME = 10 * BD;
   logic clk = 1'b0, rst = 1'b0, in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic [2:0] in_nbytes = '0;
   logic in_ready, tx, busy, done;
   int total = 0, passed = 0;

   uart_word_tx #(.BAUD_DIV(BD)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_nbytes(in_nbytes), .in_ready(in_ready), .tx(tx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [2:0]  nb;
      int          n;
      logic [31:0] eb;
   } vec_t;
   vec_t v[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Drives one word and checks the line cycle-by-cycle; stop_at aborts early.
   task automatic run_word(input logic [31:0] d, input logic [2:0] nb, input int en,
                           input logic [31:0] eb, input int pulse_at, input bit hold,
                           input int stop_at);
      int errs;
      logic [7:0] got, eby;
      logic exp_tx;
      int f, b;
      errs = 0;
      got = '0;
      @(negedge clk);
      chk("ready_before_accept", {31'd0, in_ready}, 1);
      in_valid = 1'b1;
      in_data = d;
      in_nbytes = nb;
      @(negedge clk);
      if (!hold) begin
         in_valid = 1'b0;
         in_data = '0;
         in_nbytes = 3'd1;
      end
      for (int idx = 0; idx < FRAME * en; idx++) begin
         if (idx > 0) @(negedge clk);
         if (idx == stop_at) return;
         if (idx == pulse_at) begin
            in_valid = 1'b1;
            in_data = '1;
            in_nbytes = 3'd4;
         end
         if (idx == pulse_at + 1) begin
            in_valid = 1'b0;
            in_data = '0;
         end
         f = idx / FRAME;
         b = (idx % FRAME) / BD;
         eby = eb[8*f +: 8];
         exp_tx = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eby[b-1];
         if (tx !== exp_tx || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) errs++;
         if (b >= 1 && b <= 8 && idx % BD == 2) got[b-1] = tx;
         if (idx % FRAME == FRAME - 1) chk($sformatf("frame%0d_byte", f), {24'd0, got}, {24'd0, eby});
      end
      chk("line_and_flags_hold", errs, 0);
      @(negedge clk);
      chk("done_at_10_bd_n", {28'd0, done, in_ready, busy, tx}, 32'b1101);
      if (hold) begin
         @(negedge clk);
         chk("hold_next_start", {28'd0, done, in_ready, busy, tx}, 32'b0010);
         in_valid = 1'b0;
         errs = 1;
         for (int k = 0; k < FRAME * 4 + 10 && errs != 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) errs = 0;
         end
         chk("hold_second_done", errs, 0);
      end else begin
         @(negedge clk);
         chk("done_one_cycle", {31'd0, done}, 0);
      end
   endtask

   initial begin
      v[0] = '{32'hA5C30F81, 3'd4, 4, 32'hA5C30F81};
      v[1] = '{32'h0000003C, 3'd1, 1, 32'h0000003C};
      v[2] = '{32'h12345678, 3'd0, 4, 32'h12345678};
      v[3] = '{32'h12345678, 3'd7, 4, 32'h12345678};
      v[4] = '{32'h0000005A, 3'd1, 1, 32'h0000005A};
      v[5] = '{32'hDEADBEEF, 3'd2, 2, 32'h0000BEEF};
      v[6] = '{32'h00BEEF00, 3'd3, 3, 32'h00BEEF00};
      #1 rst = 1'b1;
      #2 chk("reset_outputs", {28'd0, done, in_ready, busy, tx}, 32'b0101);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("reset_held", {28'd0, done, in_ready, busy, tx}, 32'b0101);
      foreach (v[i]) run_word(v[i].d, v[i].nb, v[i].n, v[i].eb, -10, 1'b0, -1);
      run_word(32'h11223344, 3'd4, 4, 32'h11223344, 20, 1'b0, -1);
      run_word(32'h0000C35A, 3'd2, 2, 32'h0000C35A, -10, 1'b1, -1);
      run_word(32'hA5C30F81, 3'd4, 4, 32'hA5C30F81, -10, 1'b0, 2 * FRAME + 3 * BD + 1);
      #2 rst = 1'b1;
      #1 chk("async_reset_mid_frame", {28'd0, done, in_ready, busy, tx}, 32'b0101);
      @(negedge clk);
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) seen++;
         end
         chk("no_done_after_abort", seen, 0);
      end
      run_word(32'h000000AA, 3'd1, 1, 32'h000000AA, -10, 1'b0, -1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
